// File: rtl/mult_pkg.sv
// Shared types and defaults for the iterative shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

    localparam int unsigned MULT_N_DEFAULT = 4;

endpackage

// File: rtl/mult_step.sv
// One shift-and-add iteration: conditionally add mcand into the accumulator's upper half,
// then shift the whole accumulator right by one.
module mult_step #(
    parameter int unsigned N = 4
) (
    input  logic [2*N-1:0] i_acc,
    input  logic [N-1:0]   i_mcand,
    output logic [2*N-1:0] o_acc_next
);

    logic [N:0]   w_carry;
    logic [N-1:0] w_sum;
    logic [N-1:0] w_addend;

    assign w_carry[0] = 1'b0;
    assign w_addend   = i_acc[0] ? i_mcand : '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_fa
        assign w_sum[gi]     = i_acc[N+gi] ^ w_addend[gi] ^ w_carry[gi];
        assign w_carry[gi+1] = (i_acc[N+gi] & w_addend[gi])
                             | (i_acc[N+gi] & w_carry[gi])
                             | (w_addend[gi] & w_carry[gi]);
    end

    // Carry-out becomes the new MSB; the consumed multiplier bit drops off the bottom.
    assign o_acc_next = {w_carry[N], w_sum, i_acc[N-1:1]};

endmodule

// File: rtl/seq_mult.sv
// Iterative unsigned multiplier: N-bit operands in on a start strobe, 2N-bit product out
// N cycles later with a one-cycle done pulse.
module seq_mult
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N_DEFAULT
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic           o_busy,
    output logic           o_done,
    output logic [2*N-1:0] o_product
);

    localparam int unsigned CntW = $clog2(N);

    mult_state_t     r_state;
    logic [2*N-1:0]  r_acc;
    logic [N-1:0]    r_mcand;
    logic [CntW-1:0] r_cnt;
    logic [2*N-1:0]  r_product;
    logic            r_busy;
    logic            r_done;
    logic [2*N-1:0]  w_acc_next;

    mult_step #(
        .N (N)
    ) u_step (
        .i_acc      (r_acc),
        .i_mcand    (r_mcand),
        .o_acc_next (w_acc_next)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_mcand <= i_a;
                        r_acc   <= {{N{1'b0}}, i_b};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CntW'(1);
                    if (r_cnt == CntW'(N - 1)) begin
                        r_product <= w_acc_next;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_product;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: stimulus pushes expected products and due cycles,
// a negedge monitor pops and compares on each done.
module tb_seq_mult;

    localparam int N = 4;

    typedef struct {
        logic [2*N-1:0] prod;
        int             due;
    } exp_t;

    logic           clk;
    logic           reset;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    exp_t           sb[$];
    int             cyc;
    int             errors;
    int             checks;
    logic           prev_done;
    logic [2*N-1:0] last_prod;

    seq_mult #(
        .N (N)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_start   (start),
        .i_a       (a),
        .i_b       (b),
        .o_busy    (busy),
        .o_done    (done),
        .o_product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: product must hold between dones, each done must match the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            last_prod = '0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", int'(product), int'(e.prod));
                    check("done_cycle", cyc, e.due);
                end
                check("done_single_cycle", int'(prev_done), 0);
                last_prod = product;
            end else begin
                check("product_hold", int'(product), int'(last_prod));
            end
            prev_done = done;
        end
    end

    // Called #1 after a posedge with the DUT idle; returns #1 after E(N+1).
    task automatic do_mult(input logic [N-1:0] ia, input logic [N-1:0] ib);
        exp_t e;
        a     = ia;
        b     = ib;
        start = 1'b1;
        e.prod = (2*N)'(ia) * (2*N)'(ib);
        e.due  = cyc + 1 + N;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 'x;
        b     = 'x;
        check("busy_after_e0", int'(busy), 1);
        repeat (N + 1) @(posedge clk);
        #1;
        check("busy_after_eN1", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        prev_done = 1'b0;
        last_prod = '0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_product", int'(product), 0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        do_mult(4'd3, 4'd5);
        do_mult(4'd15, 4'd15);
        do_mult(4'd0, 4'd9);
        do_mult(4'd9, 4'd0);

        // Start held high; operands changed mid-RUN are ignored until E6.
        a     = 4'd2;
        b     = 4'd3;
        start = 1'b1;
        e.prod = 8'h06;
        e.due  = cyc + 1 + N;
        sb.push_back(e);
        e.prod = 8'h31;
        e.due  = cyc + 1 + (N + 2) + N;
        sb.push_back(e);
        @(posedge clk);
        #1;
        a = 4'd7;
        b = 4'd7;
        repeat (N + 2) @(posedge clk);
        #1;
        start = 1'b0;
        check("held_busy", int'(busy), 1);
        repeat (N + 1) @(posedge clk);
        #1;
        check("held_idle", int'(busy), 0);

        // Reset mid-RUN after E2: outputs clear asynchronously, no done follows.
        do_mult(4'd3, 4'd5);
        a     = 4'd6;
        b     = 4'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrun_busy", int'(busy), 0);
        check("midrun_done", int'(done), 0);
        check("midrun_product", int'(product), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (N + 3) @(posedge clk);
        #1;
        check("no_done_after_reset", sb.size(), 0);
        do_mult(4'd4, 4'd4);

        for (int i = 0; i < (1 << N); i++) begin
            for (int j = 0; j < (1 << N); j++) begin
                do_mult(N'(i), N'(j));
            end
        end

        repeat (N + 3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
